// File: rtl/tx_fifo_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Package   : tx_fifo_pkg
// Purpose   : Default geometry and shared types for the transmit FIFO.
// Revision  : 1.0 - initial release
// ----------------------------------------------------------------------------
package tx_fifo_pkg;

  localparam int TX_DATA_W = 8;
  localparam int TX_DEPTH  = 8;
  localparam int PTR_W     = $clog2(TX_DEPTH);
  localparam int CNT_W     = PTR_W + 1;

  typedef logic [PTR_W-1:0]     ptr_t;
  typedef logic [CNT_W-1:0]     cnt_t;
  typedef logic [TX_DATA_W-1:0] data_t;

endpackage : tx_fifo_pkg
`default_nettype wire

// File: rtl/tx_fifo_ram.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module    : tx_fifo_ram
// Purpose   : DEPTH x DATA_W register file with one synchronous write port and
//             one asynchronous read port. The array is not reset.
// Revision  : 1.0 - initial release
// ----------------------------------------------------------------------------
module tx_fifo_ram
  import tx_fifo_pkg::*;
#(
  parameter  int DATA_W = TX_DATA_W,
  parameter  int DEPTH  = TX_DEPTH,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write port: store the word on the clock edge when the push is accepted
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : tx_fifo_ram
`default_nettype wire

// File: rtl/tx_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module    : tx_fifo
// Purpose   : Single-clock first-word-fall-through transmit FIFO. Holds the
//             read/write pointers, fill count, flags and optional error flag;
//             storage lives in tx_fifo_ram.
// Macros    : TX_FIFO_ERR_EN - when defined, ovf_err is a sticky flag set by a
//             dropped push or an ignored pop; otherwise ovf_err is tied low.
// Revision  : 1.0 - initial release
// ----------------------------------------------------------------------------
module tx_fifo
  import tx_fifo_pkg::*;
#(
  parameter  int DATA_W = TX_DATA_W,
  parameter  int DEPTH  = TX_DEPTH,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_enable,
  input  logic [DATA_W-1:0] w_data,
  input  logic              r_enable,
  output logic [DATA_W-1:0] r_data,
  output logic              empty,
  output logic              full,
  output logic [CW-1:0]     count,
  output logic              ovf_err
);

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q,  count_d;
  logic              w_push;
  logic              w_pop;
  logic [DATA_W-1:0] w_ram_rdata;

  // Flags depend only on the registered count, never on this cycle's inputs
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;

  // A full FIFO still takes a push when a pop frees the slot on the same edge
  assign w_push = w_enable && (!full || r_enable);
  assign w_pop  = r_enable && !empty;

  // Next-state pointers and fill level; pointers wrap by natural overflow
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  tx_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (w_push),
    .waddr_i (wr_ptr_q),
    .wdata_i (w_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (w_ram_rdata)
  );

  // Head word is forced to zero while empty so stale storage never leaks out
  assign r_data = empty ? '0 : w_ram_rdata;

`ifdef TX_FIFO_ERR_EN
  logic ovf_err_q, ovf_err_d;
  logic w_err_evt;

  // A push dropped on a full FIFO or any pop attempted while empty
  assign w_err_evt = (w_enable && full && !r_enable) || (r_enable && empty);
  assign ovf_err_d = ovf_err_q | w_err_evt;

  // Sticky error flag, only cleared by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_err_q <= 1'b0;
    end else begin
      ovf_err_q <= ovf_err_d;
    end
  end

  assign ovf_err = ovf_err_q;
`else
  assign ovf_err = 1'b0;
`endif

endmodule : tx_fifo
`default_nettype wire

// File: tb/tb_tx_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module    : tb_tx_fifo
// Purpose   : Self-checking bench for tx_fifo against a queue-based model.
//             Honours TX_FIFO_ERR_EN to select the expected ovf_err behaviour.
// Revision  : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_tx_fifo;

  localparam int DEPTH = 8;

`ifdef TX_FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       w_enable;
  logic [7:0] w_data;
  logic       r_enable;
  logic [7:0] r_data;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       ovf_err;

  int errors = 0;
  int checks = 0;

  // Behavioural model: contents in order, plus sticky error bit
  logic [7:0] m_q[$];
  bit         m_err;

  tx_fifo #(.DATA_W(8), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .w_enable (w_enable),
    .w_data   (w_data),
    .r_enable (r_enable),
    .r_data   (r_data),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .ovf_err  (ovf_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_rdata();
    return (m_q.size() != 0) ? m_q[0] : 8'h00;
  endfunction

  function automatic logic exp_err();
    return ERR_EN ? m_err : 1'b0;
  endfunction

  // Apply one cycle of stimulus; model is advanced from pre-edge state
  task automatic drive(input logic we, input logic [7:0] wd, input logic re);
    bit m_full, m_empty, do_push, do_pop;
    w_enable = we;
    w_data   = wd;
    r_enable = re;
    m_full   = (m_q.size() == DEPTH);
    m_empty  = (m_q.size() == 0);
    do_push  = we && (!m_full || re);
    do_pop   = re && !m_empty;
    if ((we && m_full && !re) || (re && m_empty)) m_err = 1'b1;
    if (do_pop) void'(m_q.pop_front());
    if (do_push) m_q.push_back(wd);
    @(posedge clk);
    #1;
    w_enable = 1'b0;
    r_enable = 1'b0;
  endtask

  // Pulse reset between clock edges
  task automatic pulse_reset();
    rst = 1'b1;
    m_q.delete();
    m_err = 1'b0;
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; w_enable = 1'b0; r_enable = 1'b0; w_data = 8'h00;
    m_q.delete(); m_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b1, 8'h11, 1'b0);
    drive(1'b1, 8'h22, 1'b0);
    drive(1'b1, 8'h33, 1'b0);
    checks++;
    if (count !== 4'd3) begin errors++; $display("FAIL prefill_count got=%0d want=3", count); end
    // Reset mid-stream: outputs must clear without a clock edge
    rst = 1'b1;
    m_q.delete(); m_err = 1'b0;
    #1;
    checks++;
    if (count !== 4'd0) begin errors++; $display("FAIL rst_count got=%0d want=0", count); end
    checks++;
    if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty got=%b want=1", empty); end
    checks++;
    if (full !== 1'b0) begin errors++; $display("FAIL rst_full got=%b want=0", full); end
    checks++;
    if (r_data !== 8'h00) begin errors++; $display("FAIL rst_rdata got=%h want=00", r_data); end
    checks++;
    if (ovf_err !== 1'b0) begin errors++; $display("FAIL rst_ovf got=%b want=0", ovf_err); end
    #1;
    rst = 1'b0;
  endtask

  task automatic test_fill_drain();
    pulse_reset();
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'(i + 1), 1'b0);
    checks++;
    if (full !== 1'b1) begin errors++; $display("FAIL fill_full got=%b want=1", full); end
    checks++;
    if (count !== 4'd8) begin errors++; $display("FAIL fill_count got=%0d want=8", count); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (r_data !== 8'(i + 1))
        begin errors++; $display("FAIL drain_rdata[%0d] got=%h want=%h", i, r_data, 8'(i + 1)); end
      drive(1'b0, 8'h00, 1'b1);
    end
    checks++;
    if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got=%b want=1", empty); end
    checks++;
    if (r_data !== 8'h00) begin errors++; $display("FAIL drain_rdata_zero got=%h want=00", r_data); end
  endtask

  task automatic test_wrap();
    pulse_reset();
    for (int i = 0; i < 6; i++) drive(1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 6; i++) drive(1'b1, 8'hA0 + 8'(i), 1'b0);
    checks++;
    if (count !== 4'd6) begin errors++; $display("FAIL wrap_count got=%0d want=6", count); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (r_data !== 8'hA0 + 8'(i))
        begin errors++; $display("FAIL wrap_rdata[%0d] got=%h want=%h", i, r_data, 8'hA0 + 8'(i)); end
      drive(1'b0, 8'h00, 1'b1);
    end
    checks++;
    if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got=%b want=1", empty); end
  endtask

  task automatic test_simul_full();
    pulse_reset();
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'h10 + 8'(i), 1'b0);
    drive(1'b1, 8'h5A, 1'b1);
    checks++;
    if (count !== 4'd8) begin errors++; $display("FAIL sfull_count got=%0d want=8", count); end
    checks++;
    if (full !== 1'b1) begin errors++; $display("FAIL sfull_full got=%b want=1", full); end
    checks++;
    if (r_data !== 8'h11) begin errors++; $display("FAIL sfull_head got=%h want=11", r_data); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (r_data !== exp_rdata())
        begin errors++; $display("FAIL sfull_rdata[%0d] got=%h want=%h", i, r_data, exp_rdata()); end
      if (i == DEPTH - 1) begin
        checks++;
        if (r_data !== 8'h5A) begin errors++; $display("FAIL sfull_last got=%h want=5a", r_data); end
      end
      drive(1'b0, 8'h00, 1'b1);
    end
  endtask

  task automatic test_simul_empty();
    pulse_reset();
    drive(1'b1, 8'h33, 1'b1);
    checks++;
    if (count !== 4'd1) begin errors++; $display("FAIL sempty_count got=%0d want=1", count); end
    checks++;
    if (r_data !== 8'h33) begin errors++; $display("FAIL sempty_rdata got=%h want=33", r_data); end
    checks++;
    if (empty !== 1'b0) begin errors++; $display("FAIL sempty_empty got=%b want=0", empty); end
    checks++;
    if (ovf_err !== ERR_EN) begin errors++; $display("FAIL sempty_ovf got=%b want=%b", ovf_err, ERR_EN); end
  endtask

  task automatic test_overflow();
    pulse_reset();
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'hC0 + 8'(i), 1'b0);
    checks++;
    if (ovf_err !== 1'b0) begin errors++; $display("FAIL ovf_pre got=%b want=0", ovf_err); end
    drive(1'b1, 8'hEE, 1'b0);
    checks++;
    if (count !== 4'd8) begin errors++; $display("FAIL ovf_count got=%0d want=8", count); end
    checks++;
    if (ovf_err !== ERR_EN) begin errors++; $display("FAIL ovf_set got=%b want=%b", ovf_err, ERR_EN); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (r_data !== 8'hC0 + 8'(i))
        begin errors++; $display("FAIL ovf_rdata[%0d] got=%h want=%h", i, r_data, 8'hC0 + 8'(i)); end
      drive(1'b0, 8'h00, 1'b1);
    end
    checks++;
    if (empty !== 1'b1) begin errors++; $display("FAIL ovf_dropped_empty got=%b want=1", empty); end
    checks++;
    if (ovf_err !== ERR_EN) begin errors++; $display("FAIL ovf_sticky got=%b want=%b", ovf_err, ERR_EN); end
    pulse_reset();
    checks++;
    if (ovf_err !== 1'b0) begin errors++; $display("FAIL ovf_cleared got=%b want=0", ovf_err); end
  endtask

  task automatic test_random();
    logic we, re;
    pulse_reset();
    for (int i = 0; i < 400; i++) begin
      // Alternate write-heavy and read-heavy phases to reach both boundaries
      if (((i / 40) % 2) == 0) begin
        we = ($urandom_range(0, 99) < 75);
        re = ($urandom_range(0, 99) < 30);
      end else begin
        we = ($urandom_range(0, 99) < 30);
        re = ($urandom_range(0, 99) < 75);
      end
      drive(we, 8'($urandom), re);
      checks++;
      if (count !== 4'(m_q.size()))
        begin errors++; $display("FAIL rnd_count[%0d] got=%0d want=%0d", i, count, m_q.size()); end
      checks++;
      if (r_data !== exp_rdata())
        begin errors++; $display("FAIL rnd_rdata[%0d] got=%h want=%h", i, r_data, exp_rdata()); end
      checks++;
      if (empty !== (m_q.size() == 0))
        begin errors++; $display("FAIL rnd_empty[%0d] got=%b want=%b", i, empty, (m_q.size() == 0)); end
      checks++;
      if (full !== (m_q.size() == DEPTH))
        begin errors++; $display("FAIL rnd_full[%0d] got=%b want=%b", i, full, (m_q.size() == DEPTH)); end
      checks++;
      if (ovf_err !== exp_err())
        begin errors++; $display("FAIL rnd_ovf[%0d] got=%b want=%b", i, ovf_err, exp_err()); end
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_simul_full();
    test_simul_empty();
    test_overflow();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against a stalled run
  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "simulation time limit exceeded");
  end

endmodule : tb_tx_fifo
`default_nettype wire
